// File: rtl/microcode_pkg.sv
// Shared definitions for the RV32I stage-1 microcode encoder and its decoder:
// ALU op encodings, opcode constants and microcode word field offsets.
package microcode_pkg;

  typedef enum logic [3:0] {
    AluAdd  = 4'b0000,
    AluSub  = 4'b0001,
    AluSlt  = 4'b0010,
    AluSltu = 4'b0011,
    AluXor  = 4'b0100,
    AluOr   = 4'b0101,
    AluAnd  = 4'b0110,
    AluSll  = 4'b0111,
    AluSrl  = 4'b1000,
    AluSra  = 4'b1001
  } alu_ops_e;

  localparam logic [6:0] OpcodeOp    = 7'b0110011;
  localparam logic [6:0] OpcodeOpImm = 7'b0010011;
  localparam logic [6:0] OpcodeLui   = 7'b0110111;

  localparam int unsigned McWidth       = 22;
  localparam int unsigned McAluLsb      = 0;
  localparam int unsigned McSrcBImmBit  = 4;
  localparam int unsigned McRegWriteBit = 5;
  localparam int unsigned McRdLsb       = 6;
  localparam int unsigned McRs1Lsb      = 11;
  localparam int unsigned McRs2Lsb      = 16;
  localparam int unsigned McReservedBit = 21;

  // alt selects SUB/SRA; callers mask it where the opcode has no alternate form.
  function automatic alu_ops_e alu_from_funct3(input logic [2:0] funct3, input logic alt);
    case (funct3)
      3'b000:  return alt ? AluSub : AluAdd;
      3'b001:  return AluSll;
      3'b010:  return AluSlt;
      3'b011:  return AluSltu;
      3'b100:  return AluXor;
      3'b101:  return alt ? AluSra : AluSrl;
      3'b110:  return AluOr;
      default: return AluAnd;
    endcase
  endfunction

  function automatic logic [McWidth-1:0] pack_mc(input alu_ops_e alu, input logic src_b_imm,
                                                 input logic reg_write, input logic [4:0] rd,
                                                 input logic [4:0] rs1, input logic [4:0] rs2);
    logic [McWidth-1:0] w;
    w = '0;
    w[McAluLsb +: 4]   = alu;
    w[McSrcBImmBit]    = src_b_imm;
    w[McRegWriteBit]   = reg_write;
    w[McRdLsb +: 5]    = rd;
    w[McRs1Lsb +: 5]   = rs1;
    w[McRs2Lsb +: 5]   = rs2;
    w[McReservedBit]   = 1'b0;
    return w;
  endfunction

endpackage

// File: rtl/rv32i_op_decoder.sv
// Combinational RV32I OP / OP-IMM / LUI decode into a stage-1 microcode word and immediate.
// Anything else flags illegal and yields an all-zero word (a NOP with reg_write 0).
module rv32i_op_decoder
  import microcode_pkg::*;
(
  input  logic [31:0]        instr_i,
  output logic [McWidth-1:0] mc_word_o,
  output logic [31:0]        imm_o,
  output logic               illegal_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [4:0] rd, rs1, rs2;
  logic       alt;
  logic       is_shift;

  assign opcode   = instr_i[6:0];
  assign rd       = instr_i[11:7];
  assign funct3   = instr_i[14:12];
  assign rs1      = instr_i[19:15];
  assign rs2      = instr_i[24:20];
  assign alt      = instr_i[30];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  always_comb begin
    mc_word_o = '0;
    imm_o     = '0;
    illegal_o = 1'b1;
    case (opcode)
      OpcodeOp: begin
        illegal_o = 1'b0;
        mc_word_o = pack_mc(alu_from_funct3(funct3, alt), 1'b0, 1'b1, rd, rs1, rs2);
      end
      OpcodeOpImm: begin
        illegal_o = 1'b0;
        // Only SRAI has an alternate form among the immediate ops.
        mc_word_o = pack_mc(alu_from_funct3(funct3, alt && (funct3 == 3'b101)), 1'b1, 1'b1,
                            rd, rs1, 5'd0);
        imm_o     = is_shift ? {27'd0, instr_i[24:20]} : {{20{instr_i[31]}}, instr_i[31:20]};
      end
      OpcodeLui: begin
        illegal_o = 1'b0;
        mc_word_o = pack_mc(AluAdd, 1'b1, 1'b1, rd, 5'd0, 5'd0);
        imm_o     = {instr_i[31:12], 12'd0};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/microcode_s1_encoder.sv
// Stage-1 microcode encoder: registered output entry plus optional skid entry, handoff counter.
// Define ILLEGAL_TRAP_EN to drop illegal instructions and pulse illegal instead of issuing a NOP.
module microcode_s1_encoder
  import microcode_pkg::*;
#(
  parameter int unsigned SKID_EN = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clk_enable,
  input  logic [31:0]  instr,
  input  logic         instr_valid,
  output logic         instr_ready,
  output logic [21:0]  microcode_s1,
  output logic [31:0]  imm,
  output logic         mc_valid,
  input  logic         mc_ready,
  output logic         illegal,
  output logic [15:0]  issued_count
);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} occ_e;

  occ_e               state_q;
  logic               mc_valid_q, illegal_q;
  logic [McWidth-1:0] out_word_q, skid_word_q, dec_word;
  logic [31:0]        out_imm_q, skid_imm_q, dec_imm;
  logic [15:0]        count_q;
  logic               dec_illegal, accept, handoff, push, illegal_set;

  rv32i_op_decoder u_dec (
    .instr_i   (instr),
    .mc_word_o (dec_word),
    .imm_o     (dec_imm),
    .illegal_o (dec_illegal)
  );

  always_comb begin
    if (SKID_EN != 0) begin
      instr_ready = rst_n && (state_q != StFull);
    end else begin
      instr_ready = rst_n && ((state_q == StEmpty) || mc_ready);
    end
  end

  assign accept  = instr_valid && instr_ready && clk_enable;
  assign handoff = mc_valid_q && mc_ready && clk_enable;

`ifdef ILLEGAL_TRAP_EN
  assign push        = accept && !dec_illegal;
  assign illegal_set = accept && dec_illegal;
`else
  logic unused_dec_illegal;
  assign unused_dec_illegal = dec_illegal;
  assign push               = accept;
  assign illegal_set        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StEmpty;
      mc_valid_q  <= 1'b0;
      out_word_q  <= '0;
      out_imm_q   <= '0;
      skid_word_q <= '0;
      skid_imm_q  <= '0;
      illegal_q   <= 1'b0;
      count_q     <= '0;
    end else if (clk_enable) begin
      illegal_q <= illegal_set;
      if (handoff) count_q <= count_q + 16'd1;
      case (state_q)
        StEmpty: begin
          if (push) begin
            out_word_q <= dec_word;
            out_imm_q  <= dec_imm;
            mc_valid_q <= 1'b1;
            state_q    <= StOne;
          end
        end
        StOne: begin
          if (push && handoff) begin
            out_word_q <= dec_word;
            out_imm_q  <= dec_imm;
          end else if (push) begin
            skid_word_q <= dec_word;
            skid_imm_q  <= dec_imm;
            state_q     <= StFull;
          end else if (handoff) begin
            mc_valid_q <= 1'b0;
            state_q    <= StEmpty;
          end
        end
        StFull: begin
          if (handoff) begin
            out_word_q <= skid_word_q;
            out_imm_q  <= skid_imm_q;
            state_q    <= StOne;
          end
        end
        default: begin
          mc_valid_q <= 1'b0;
          state_q    <= StEmpty;
        end
      endcase
    end else begin
      illegal_q <= 1'b0;
    end
  end

  assign microcode_s1 = out_word_q;
  assign imm          = out_imm_q;
  assign mc_valid     = mc_valid_q;
  assign illegal      = illegal_q;
  assign issued_count = count_q;

endmodule

// File: tb/tb_microcode_s1_encoder.sv
// Directed self-checking bench for microcode_s1_encoder (default SKID_EN=1).
// Expectations for illegal handling follow ILLEGAL_TRAP_EN when defined for the build.
module tb_microcode_s1_encoder;

  logic        clk = 1'b0;
  logic        rst_n, clk_enable, instr_valid, instr_ready, mc_valid, mc_ready, illegal;
  logic [31:0] instr, imm;
  logic [21:0] microcode_s1;
  logic [15:0] issued_count;

  int n_tests = 0;
  int n_fail  = 0;

  microcode_s1_encoder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clk_enable   (clk_enable),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .microcode_s1 (microcode_s1),
    .imm          (imm),
    .mc_valid     (mc_valid),
    .mc_ready     (mc_ready),
    .illegal      (illegal),
    .issued_count (issued_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // Hand-packed microcode word: [3:0] alu, [4] src_b_imm, [5] reg_write, rd, rs1, rs2.
  function automatic logic [31:0] mk(input logic [3:0] alu, input logic b, input logic rw,
                                     input logic [4:0] rd, input logic [4:0] rs1,
                                     input logic [4:0] rs2);
    return {10'd0, 1'b0, rs2, rs1, rd, rw, b, alu};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; clk_enable = 1'b1; instr_valid = 1'b0; mc_ready = 1'b0; instr = '0;
    tick(); tick();
    chk("rst_mc_valid", 32'(mc_valid), 32'd0);
    chk("rst_word", 32'(microcode_s1), 32'd0);
    chk("rst_imm", imm, 32'd0);
    chk("rst_count", 32'(issued_count), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_ready_low", 32'(instr_ready), 32'd0);
    rst_n = 1'b1; #1;
    chk("ready_after_rst", 32'(instr_ready), 32'd1);

    // add x3,x1,x2
    instr = 32'h002081B3; instr_valid = 1'b1; mc_ready = 1'b1;
    tick();
    chk("add_valid", 32'(mc_valid), 32'd1);
    chk("add_word", 32'(microcode_s1), mk(4'b0000, 1'b0, 1'b1, 5'd3, 5'd1, 5'd2));
    chk("add_imm", imm, 32'd0);
    instr_valid = 1'b0;
    tick();
    chk("add_drain_valid", 32'(mc_valid), 32'd0);
    chk("add_drain_count", 32'(issued_count), 32'd1);

    // srai x1,x1,4 then streaming sub / addi / lui / or / sll
    instr = 32'h4040D093; instr_valid = 1'b1;
    tick();
    chk("srai_alu", 32'(microcode_s1[3:0]), 32'h9);
    chk("srai_rd", 32'(microcode_s1[10:6]), 32'd1);
    chk("srai_rs1", 32'(microcode_s1[15:11]), 32'd1);
    chk("srai_srcb", 32'(microcode_s1[4]), 32'd1);
    chk("srai_rw", 32'(microcode_s1[5]), 32'd1);
    chk("srai_imm", imm, 32'h00000004);
    instr = 32'h402081B3;
    tick();
    chk("sub_word", 32'(microcode_s1), mk(4'b0001, 1'b0, 1'b1, 5'd3, 5'd1, 5'd2));
    instr = 32'hFFF00293;
    tick();
    chk("addi_alu", 32'(microcode_s1[3:0]), 32'h0);
    chk("addi_rd", 32'(microcode_s1[10:6]), 32'd5);
    chk("addi_srcb", 32'(microcode_s1[4]), 32'd1);
    chk("addi_imm", imm, 32'hFFFFFFFF);
    instr = 32'h123452B7;
    tick();
    chk("lui_alu", 32'(microcode_s1[3:0]), 32'h0);
    chk("lui_rd", 32'(microcode_s1[10:6]), 32'd5);
    chk("lui_rs1", 32'(microcode_s1[15:11]), 32'd0);
    chk("lui_srcb", 32'(microcode_s1[4]), 32'd1);
    chk("lui_imm", imm, 32'h12345000);
    instr = 32'h0020E1B3;
    tick();
    chk("or_word", 32'(microcode_s1), mk(4'b0101, 1'b0, 1'b1, 5'd3, 5'd1, 5'd2));
    instr = 32'h002091B3;
    tick();
    chk("sll_word", 32'(microcode_s1), mk(4'b0111, 1'b0, 1'b1, 5'd3, 5'd1, 5'd2));
    instr_valid = 1'b0;
    tick();
    chk("stream_valid", 32'(mc_valid), 32'd0);
    chk("stream_count", 32'(issued_count), 32'd7);

    // Stall: nothing moves while clk_enable is low
    instr = 32'h0020F1B3; instr_valid = 1'b1; clk_enable = 1'b0;
    tick();
    chk("stall_no_accept", 32'(mc_valid), 32'd0);
    clk_enable = 1'b1;
    tick();
    chk("and_word", 32'(microcode_s1), mk(4'b0110, 1'b0, 1'b1, 5'd3, 5'd1, 5'd2));
    instr_valid = 1'b0; clk_enable = 1'b0;
    tick();
    chk("stall_hold_valid", 32'(mc_valid), 32'd1);
    chk("stall_hold_count", 32'(issued_count), 32'd7);
    clk_enable = 1'b1;
    tick();
    chk("unstall_count", 32'(issued_count), 32'd8);

    // Illegal opcode
    instr = 32'h00000000; instr_valid = 1'b1;
    tick();
`ifdef ILLEGAL_TRAP_EN
    chk("trap_no_entry", 32'(mc_valid), 32'd0);
    chk("trap_pulse", 32'(illegal), 32'd1);
    instr_valid = 1'b0;
    tick();
    chk("trap_pulse_end", 32'(illegal), 32'd0);
    chk("trap_count", 32'(issued_count), 32'd8);
`else
    chk("nop_valid", 32'(mc_valid), 32'd1);
    chk("nop_word", 32'(microcode_s1), 32'd0);
    chk("nop_imm", imm, 32'd0);
    chk("nop_illegal", 32'(illegal), 32'd0);
    instr_valid = 1'b0;
    tick();
    chk("nop_count", 32'(issued_count), 32'd9);
`endif

    // Skid: three back-to-back words with the consumer stalled
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; mc_ready = 1'b0;
    instr = 32'h002081B3; instr_valid = 1'b1;
    tick();
    instr = 32'h402081B3; #1;
    chk("skid_ready_2nd", 32'(instr_ready), 32'd1);
    tick();
    instr = 32'h0020E1B3; #1;
    chk("skid_ready_3rd", 32'(instr_ready), 32'd0);
    tick();
    chk("skid_hold1", 32'(microcode_s1), mk(4'b0000, 1'b0, 1'b1, 5'd3, 5'd1, 5'd2));
    tick();
    chk("skid_hold2", 32'(microcode_s1), mk(4'b0000, 1'b0, 1'b1, 5'd3, 5'd1, 5'd2));
    chk("skid_hold_count", 32'(issued_count), 32'd0);
    instr_valid = 1'b0; mc_ready = 1'b1;
    tick();
    chk("skid_drain_2nd", 32'(microcode_s1), mk(4'b0001, 1'b0, 1'b1, 5'd3, 5'd1, 5'd2));
    chk("skid_drain_valid", 32'(mc_valid), 32'd1);
    tick();
    chk("skid_empty", 32'(mc_valid), 32'd0);
    chk("skid_count", 32'(issued_count), 32'd2);

    // Reset while FULL discards both entries
    mc_ready = 1'b0; instr_valid = 1'b1; instr = 32'h002081B3;
    tick(); tick();
    chk("full_ready", 32'(instr_ready), 32'd0);
    rst_n = 1'b0; instr_valid = 1'b0;
    tick();
    chk("rstfull_valid", 32'(mc_valid), 32'd0);
    chk("rstfull_count", 32'(issued_count), 32'd0);
    rst_n = 1'b1; #1;
    chk("rstfull_ready", 32'(instr_ready), 32'd1);
    mc_ready = 1'b1;
    tick();
    chk("rstfull_discard", 32'(mc_valid), 32'd0);

    // Counter wrap: continuous stream, one handoff per cycle after the first
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; instr_valid = 1'b1; mc_ready = 1'b1;
    for (int i = 0; i < 65536; i++) tick();
    chk("count_ffff", 32'(issued_count), 32'h0000FFFF);
    tick();
    chk("count_wrap", 32'(issued_count), 32'h00000000);
    instr_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
